// File: rtl/gate_sweep_pkg.sv
// Shared types, sizes and the expected-output rule for the gate sweep sequencer.
// Swapping the gate variant only requires editing expected_out.
package gate_sweep_pkg;

    localparam int unsigned N_VEC = 16;
    localparam int unsigned VEC_W = 4;
    localparam int unsigned ERR_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    function automatic logic expected_out(input logic [VEC_W-1:0] v);
        return &v;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Sweep control/status bundle between the sequencer (slave) and its user (master).
interface gate_sweep_ctrl_if;
    import gate_sweep_pkg::*;

    logic             start;
    logic             y_in;
    logic [VEC_W-1:0] abcd;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [N_VEC-1:0] fail_vec;

    modport master (
        output start, y_in,
        input  abcd, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  start, y_in,
        output abcd, busy, done, pass, err_cnt, fail_vec
    );

endinterface

// File: rtl/settle_timer.sv
// Settle counter: counts enabled cycles from a clear; expired marks the last settle cycle.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Clocked sweep of all 16 gate input vectors with per-vector pass/fail capture.
// Optional GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    gate_sweep_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] abcd_q, abcd_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_VEC-1:0] fail_q, fail_d;
    logic             busy_q, busy_d;
    logic             tmr_clear, tmr_en, tmr_expired;
    logic             mismatch, last_vec;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        abcd_d    = abcd_q;
        err_d     = err_q;
        fail_d    = fail_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        mismatch  = (expected_out(abcd_q) != bus.y_in);
        last_vec  = (abcd_q == '1);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    abcd_d    = '0;
                    err_d     = '0;
                    fail_d    = '0;
                    tmr_clear = 1'b1;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    fail_d[abcd_q] = 1'b1;
                    err_d          = err_q + ERR_W'(1);
                end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                if (mismatch || last_vec) begin
`else
                if (last_vec) begin
`endif
                    state_d = StDone;
                end else begin
                    abcd_d    = abcd_q + VEC_W'(1);
                    tmr_clear = 1'b1;
                    state_d   = StSettle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StSettle) || (state_d == StCheck);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            abcd_q  <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            abcd_q  <= abcd_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.abcd     = abcd_q;
    assign bus.busy     = busy_q;
    assign bus.done     = (state_q == StDone);
    assign bus.pass     = (err_q == '0);
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench: two sequencers (settle 2 and 1) driven by random gate truth tables.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    logic clk  = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;
    int   cyc  = 0;

    logic [15:0] tbl0 = 16'h8000;
    logic [15:0] tbl1 = 16'h8000;

    gate_sweep_ctrl_if if0 ();
    gate_sweep_ctrl_if if1 ();

    assign if0.y_in = tbl0[if0.abcd];
    assign if1.y_in = tbl1[if1.abcd];

    gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
    gate_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] fv;
        int          err;
        logic        pass;
        logic [3:0]  last;
        int          nvec;
        int          done_at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   steps[2]   = '{0, 0};
    int   last_a[2]  = '{-1, -1};
    bit   seq_bad[2] = '{1'b0, 1'b0};

    // Reference: the gate must output 1 only for vector 15; every other disagreement is a failure.
    function automatic exp_t model(input logic [15:0] tbl, input int sc, input int s);
        exp_t e;
        e.fv   = '0;
        e.err  = 0;
        e.nvec = 16;
        for (int v = 0; v < 16; v++) begin
            if (v < e.nvec && tbl[v] != (v == 15)) begin
                e.fv[v] = 1'b1;
                e.err++;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                e.nvec = v + 1;
`endif
            end
        end
        e.last    = 4'(e.nvec - 1);
        e.pass    = (e.err == 0);
        e.done_at = s + e.nvec * (sc + 1);
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic r, input logic done, input logic busy,
                       input logic [3:0] a, input logic [4:0] ec, input logic [15:0] fv,
                       input logic pass);
        exp_t e;
        bit   have;
        if (r) begin
            steps[id] = 0; last_a[id] = -1; seq_bad[id] = 1'b0;
            return;
        end
        if (busy && int'(a) != last_a[id]) begin
            if (int'(a) != steps[id]) seq_bad[id] = 1'b1;
            steps[id]++;
            last_a[id] = int'(a);
        end
        if (done) begin
            have = 1'b0;
            if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_done dut%0d: got done, expected none (cycle %0d)", id, cyc);
            end else begin
                chk($sformatf("dut%0d done_cycle", id), cyc, e.done_at);
                chk($sformatf("dut%0d fail_vec", id), fv, e.fv);
                chk($sformatf("dut%0d err_cnt", id), ec, e.err);
                chk($sformatf("dut%0d pass", id), pass, e.pass);
                chk($sformatf("dut%0d abcd_final", id), a, e.last);
                chk($sformatf("dut%0d busy_at_done", id), busy, 0);
                chk($sformatf("dut%0d abcd_steps", id), steps[id], e.nvec);
                chk($sformatf("dut%0d abcd_order", id), seq_bad[id], 0);
            end
            steps[id] = 0; last_a[id] = -1; seq_bad[id] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, rst0, if0.done, if0.busy, if0.abcd, if0.err_cnt, if0.fail_vec, if0.pass);
            mon(1, rst1, if1.done, if1.busy, if1.abcd, if1.err_cnt, if1.fail_vec, if1.pass);
        end
    end

    task automatic set_start(input int id, input logic v);
        if (id == 0) if0.start = v;
        else         if1.start = v;
    endtask

    task automatic sweep_start(input int id, output int s);
        @(negedge clk);
        set_start(id, 1'b1);
        @(posedge clk);
        #1 s = cyc;
        @(negedge clk);
        set_start(id, 1'b0);
    endtask

    task automatic wait_drain(input int id, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL timeout dut%0d: got no done, expected done within %0d cycles", id, budget);
        if (id == 0) q0.delete();
        else         q1.delete();
    endtask

    task automatic run(input int id, input logic [15:0] tbl);
        int s;
        if (id == 0) tbl0 = tbl;
        else         tbl1 = tbl;
        sweep_start(id, s);
        if (id == 0) q0.push_back(model(tbl, 2, s));
        else         q1.push_back(model(tbl, 1, s));
        wait_drain(id, 200);
        repeat ($urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, " abcd"}, if0.abcd, 0);
        chk({tag, " busy"}, if0.busy, 0);
        chk({tag, " done"}, if0.done, 0);
        chk({tag, " err_cnt"}, if0.err_cnt, 0);
        chk({tag, " fail_vec"}, if0.fail_vec, 0);
        chk({tag, " pass"}, if0.pass, 1);
    endtask

    initial begin
        int  s;
        bit  found;
        if0.start = 1'b0;
        if1.start = 1'b0;
        #1 rst0 = 1'b1; rst1 = 1'b1;
        #2 chk_reset0("por");
        repeat (2) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;

        run(0, 16'h8000);
        run(0, 16'h0000);
        run(0, 16'hFFFE);
        for (int i = 0; i < 6; i++) run(0, 16'($urandom()));

        // Settle of 1 with a second start mid-sweep that must be ignored.
        tbl1 = 16'h8000;
        sweep_start(1, s);
        q1.push_back(model(16'h8000, 1, s));
        repeat (9) @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        wait_drain(1, 200);
        for (int i = 0; i < 4; i++) run(1, 16'($urandom()));

        // Reset while vector 7 settles, with errors already accumulated.
        tbl0 = 16'hFFFE;
        sweep_start(0, s);
        q0.push_back(model(16'hFFFE, 2, s));
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (if0.busy && if0.abcd == 4'd7) found = 1'b1;
        end
        chk("reach_vec7", found, 1);
        rst0 = 1'b1;
        q0.delete();
        #1 chk_reset0("midrst");
        @(negedge clk);
        rst0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst busy", if0.busy, 0);
        run(0, 16'h8000);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
